// File: rtl/mw_timer_ctrl.sv
// Microwave cook-timer controller: keypad entry of an M:SS BCD time, a 1 s countdown while cooking,
// and magnetron gating from start/stop/clear/door inputs.
module mw_timer_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] min,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       done,
  output logic [1:0] state
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        cur_state, nxt_state;
  logic [3:0]    min_n, tens_n, ones_n;
  logic [PW-1:0] pre, pre_n;
  logic          tick, time_nz, last_sec;

  assign state    = cur_state;
  assign tick     = (pre == PW'(TICK_DIV - 1));
  assign time_nz  = ({min, sec_tens, sec_ones} != 12'd0);
  assign last_sec = (min == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state    <= S_IDLE;
      min          <= 4'd0;
      sec_tens     <= 4'd0;
      sec_ones     <= 4'd0;
      pre          <= '0;
      magnetron_on <= 1'b0;
      done         <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      min          <= min_n;
      sec_tens     <= tens_n;
      sec_ones     <= ones_n;
      pre          <= pre_n;
      magnetron_on <= (nxt_state == S_RUN);
      done         <= (nxt_state == S_DONE);
    end
  end

  // Each state acts on only the highest-priority event present this cycle:
  // clear > stop > door open > start > key.
  always_comb begin
    nxt_state = cur_state;
    min_n     = min;
    tens_n    = sec_tens;
    ones_n    = sec_ones;
    pre_n     = pre;
    case (cur_state)
      S_IDLE: begin
        if (clear) begin
          min_n  = 4'd0;
          tens_n = 4'd0;
          ones_n = 4'd0;
        end else if (stop) begin
          nxt_state = S_IDLE;
        end else if (start) begin
          if (door_closed && time_nz) begin
            nxt_state = S_RUN;
            pre_n     = '0;
          end
        end else if (key_valid && (key_digit <= 4'd9) && (sec_ones <= 4'd5)) begin
          // A ones digit above 5 would become an illegal tens-of-seconds digit.
          min_n  = sec_tens;
          tens_n = sec_ones;
          ones_n = key_digit;
        end
      end
      S_RUN: begin
        if (clear) begin
          nxt_state = S_IDLE;
          min_n     = 4'd0;
          tens_n    = 4'd0;
          ones_n    = 4'd0;
        end else if (stop || !door_closed) begin
          nxt_state = S_PAUSE;
        end else if (tick) begin
          pre_n = '0;
          if (sec_ones != 4'd0) begin
            ones_n = sec_ones - 4'd1;
          end else begin
            ones_n = 4'd9;
            if (sec_tens != 4'd0) begin
              tens_n = sec_tens - 4'd1;
            end else begin
              tens_n = 4'd5;
              min_n  = min - 4'd1;
            end
          end
          if (last_sec) nxt_state = S_DONE;
        end else begin
          pre_n = pre + PW'(1);
        end
      end
      S_PAUSE: begin
        if (clear || stop) begin
          nxt_state = S_IDLE;
          min_n     = 4'd0;
          tens_n    = 4'd0;
          ones_n    = 4'd0;
        end else if (door_closed && start) begin
          nxt_state = S_RUN;
        end
      end
      default: begin
        min_n  = 4'd0;
        tens_n = 4'd0;
        ones_n = 4'd0;
        if (clear || stop || start || key_valid) nxt_state = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mw_timer_ctrl.sv
// Bench for mw_timer_ctrl: directed scenarios followed by random traffic, all checked every cycle
// against a seconds-based reference model of the cook timer.
module tb_mw_timer_ctrl;

  localparam int TICK = 4;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
  logic [3:0] min, sec_tens, sec_ones;
  logic       magnetron_on, done;
  logic [1:0] state;

  always #5 clk = ~clk;

  mw_timer_ctrl #(.TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
    .min(min), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .magnetron_on(magnetron_on), .done(done), .state(state)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: time held as total seconds, run progress as cycles spent cooking.
  int m_state = 0;   // 0 idle, 1 cooking, 2 paused, 3 finished
  int m_secs = 0;
  int m_acc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int m, input int t, input int o);
    chk({tag, "_min"}, {28'd0, min}, m);
    chk({tag, "_tens"}, {28'd0, sec_tens}, t);
    chk({tag, "_ones"}, {28'd0, sec_ones}, o);
  endtask

  task automatic check_model();
    chk("state", {30'd0, state}, m_state);
    chk_time("model", m_secs / 60, (m_secs % 60) / 10, m_secs % 10);
    chk("magnetron_on", {31'd0, magnetron_on}, (m_state == 1) ? 1 : 0);
    chk("done", {31'd0, done}, (m_state == 3) ? 1 : 0);
  endtask

  function automatic void model_step();
    case (m_state)
      0: begin
        if (clear) m_secs = 0;
        else if (stop) m_secs = m_secs;
        else if (start) begin
          if (door_closed && m_secs != 0) begin
            m_state = 1;
            m_acc = 0;
          end
        end else if (key_valid && key_digit <= 9 && (m_secs % 10) <= 5)
          m_secs = ((m_secs % 60) / 10) * 60 + (m_secs % 10) * 10 + int'(key_digit);
      end
      1: begin
        if (clear) begin
          m_state = 0;
          m_secs = 0;
        end else if (stop || !door_closed) m_state = 2;
        else begin
          m_acc++;
          if (m_acc == TICK) begin
            m_acc = 0;
            m_secs--;
            if (m_secs == 0) m_state = 3;
          end
        end
      end
      2: begin
        if (clear || stop) begin
          m_state = 0;
          m_secs = 0;
        end else if (door_closed && start) m_state = 1;
      end
      default: if (clear || stop || start || key_valid) m_state = 0;
    endcase
  endfunction

  // driver tasks
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_model();
    key_valid = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    clear = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();
    chk_time("reset", 0, 0, 0);

    // key entry, out-of-range digit ignored
    press(4'd1); press(4'd3); press(4'd0); press(4'd12);
    chk_time("entry_130", 1, 3, 0);
    do_clear();
    press(4'd0); press(4'd8); press(4'd5);
    chk_time("entry_008", 0, 0, 8);

    // countdown from 1:30, minute borrow at 1:00
    do_clear();
    press(4'd1); press(4'd3); press(4'd0);
    do_start();
    chk("run_state", {30'd0, state}, 1);
    chk("run_mag", {31'd0, magnetron_on}, 1);
    run(TICK);
    chk_time("dec_129", 1, 2, 9);
    run(29 * TICK);
    chk_time("dec_100", 1, 0, 0);
    run(TICK);
    chk_time("dec_059", 0, 5, 9);

    // asynchronous reset mid-run
    #2;
    rst = 1'b1;
    #1;
    chk("async_state", {30'd0, state}, 0);
    chk("async_mag", {31'd0, magnetron_on}, 0);
    chk_time("async", 0, 0, 0);
    m_state = 0; m_secs = 0; m_acc = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_model();

    // run to completion, key leaves DONE without being captured
    press(4'd2);
    do_start();
    run(TICK);
    chk_time("fin_001", 0, 0, 1);
    run(TICK);
    chk_time("fin_000", 0, 0, 0);
    chk("fin_done", {31'd0, done}, 1);
    chk("fin_mag", {31'd0, magnetron_on}, 0);
    press(4'd5);
    chk("fin_idle", {30'd0, state}, 0);
    chk_time("fin_key", 0, 0, 0);

    // door opened mid-step pauses with the prescaler held
    press(4'd4); press(4'd5);
    do_start();
    run(2);
    door_closed = 1'b0;
    step();
    chk("pause_state", {30'd0, state}, 2);
    run(3);
    chk_time("pause_hold", 0, 4, 5);
    door_closed = 1'b1;
    do_start();
    step();
    chk_time("resume_1", 0, 4, 5);
    step();
    chk_time("resume_2", 0, 4, 4);
    door_closed = 1'b0;
    step();
    stop = 1'b1;
    step();
    door_closed = 1'b1;
    chk("cancel_state", {30'd0, state}, 0);
    chk_time("cancel", 0, 0, 0);

    // start refused at 0:00 or with door open; clear beats start
    do_start();
    chk("start_zero", {30'd0, state}, 0);
    press(4'd7);
    door_closed = 1'b0;
    do_start();
    chk("start_door", {30'd0, state}, 0);
    door_closed = 1'b1;
    start = 1'b1;
    clear = 1'b1;
    step();
    chk("start_clear", {30'd0, state}, 0);
    chk_time("start_clear", 0, 0, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      key_valid = ($urandom_range(0, 3) == 0);
      key_digit = 4'($urandom_range(0, 15));
      start = ($urandom_range(0, 7) == 0);
      stop = ($urandom_range(0, 19) == 0);
      clear = ($urandom_range(0, 39) == 0);
      door_closed = ($urandom_range(0, 15) != 0);
      step();
    end

    // report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
